fir_cfg_ctrl: RTL and testbench

Configuration sequencer for the dual-channel FIR filter. It accepts single-word host commands (write coefficient, read coefficient, set result shift, flush) over a valid/ready command channel. It drives the filter's coefficient, result-shift and flush ports with the correct pulse/handshake timing, and returns exactly one response per command. It sits between the host register bridge and the FIR instance, and is the only writer of the filter configuration ports.

---
 rtl/fir_cfg_pkg.sv | 31 +++
 rtl/cfg_timeout_cnt.sv | 31 +++
 rtl/fir_cfg_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fir_cfg_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_cfg_pkg.sv
// rtl/fir_cfg_pkg.sv - shared opcodes, FSM encoding and width helper for the FIR config sequencer
package fir_cfg_pkg;

   localparam logic [1:0] OP_WR_COEF   = 2'd0;
   localparam logic [1:0] OP_RD_COEF   = 2'd1;
   localparam logic [1:0] OP_SET_SHIFT = 2'd2;
   localparam logic [1:0] OP_FLUSH     = 2'd3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CHECK,
      ST_WR_PULSE,
      ST_WR_WAIT,
      ST_RD_SET,
      ST_RD_CAP,
      ST_SH_PULSE,
      ST_SH_WAIT,
      ST_FLUSH,
      ST_RESP
   } state_t;

   // Never returns less than 1 so single-entry ranges still get a real port.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/cfg_timeout_cnt.sv
// rtl/cfg_timeout_cnt.sv - wait-cycle counter flagging the last cycle before a filter timeout
module cfg_timeout_cnt
   import fir_cfg_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int CW = clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   // expired marks the TIMEOUT-th wait cycle; the counter then parks until cleared.
   assign expired = (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/fir_cfg_ctrl.sv
// rtl/fir_cfg_ctrl.sv - host command sequencer driving the FIR filter coefficient, shift and flush ports
module fir_cfg_ctrl
   import fir_cfg_pkg::*;
#(
   parameter int COEF_WIDTH   = 24,
   parameter int COEF_COUNT   = 16,
   parameter int MAX_SHIFT    = 32,
   parameter int TIMEOUT      = 15,
   parameter int FLUSH_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [1:0]                    cmd_op,
   input  logic [clog2(COEF_COUNT)-1:0]  cmd_addr,
   input  logic [COEF_WIDTH-1:0]         cmd_data,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [COEF_WIDTH-1:0]         rsp_data,
   output logic                          rsp_err,
   output logic                          busy,
   output logic [clog2(COEF_COUNT)-1:0]  f_addr,
   output logic [COEF_WIDTH-1:0]         f_coef,
   output logic                          f_coef_ready,
   input  logic                          f_coef_done,
   input  logic [COEF_WIDTH-1:0]         f_coef_r,
   output logic                          f_shift_ready,
   output logic [clog2(MAX_SHIFT)-1:0]   f_shift_i,
   input  logic                          f_shift_done,
   output logic                          f_flush
);

   localparam int AW = clog2(COEF_COUNT);
   localparam int SW = clog2(MAX_SHIFT);
   localparam int FW = clog2(FLUSH_CYCLES + 1);
   localparam logic [AW:0]           ADDR_END  = (AW + 1)'(COEF_COUNT);
   localparam logic [COEF_WIDTH-1:0] SHIFT_END = COEF_WIDTH'(MAX_SHIFT);

   state_t                state;
   state_t                state_nx;
   logic                  err_nx;
   logic [1:0]            op_q;
   logic [AW-1:0]         addr_q;
   logic [COEF_WIDTH-1:0] data_q;
   logic [FW-1:0]         flush_cnt;
   logic                  accept;
   logic                  addr_bad;
   logic                  shift_bad;
   logic                  to_clear;
   logic                  to_en;
   logic                  to_expired;

   // Strobes decode straight from state so reset drops them without waiting for a clock.
   assign cmd_ready     = ~rst & (state == ST_IDLE) & ~rsp_valid;
   assign accept        = cmd_valid & cmd_ready;
   assign busy          = (state != ST_IDLE);
   assign rsp_valid     = (state == ST_RESP);
   assign f_coef_ready  = (state == ST_WR_PULSE);
   assign f_shift_ready = (state == ST_SH_PULSE);
   assign f_flush       = (state == ST_FLUSH);

   assign addr_bad  = ({1'b0, addr_q} >= ADDR_END);
   assign shift_bad = (data_q >= SHIFT_END);
   assign to_clear  = f_coef_ready | f_shift_ready;
   assign to_en     = (state == ST_WR_WAIT) | (state == ST_SH_WAIT);

   cfg_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (to_clear),
      .en      (to_en),
      .expired (to_expired)
   );

   always_comb begin
      state_nx = state;
      err_nx   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) state_nx = ST_CHECK;
         end
         ST_CHECK: begin
            if ((op_q == OP_WR_COEF || op_q == OP_RD_COEF) && addr_bad) begin
               state_nx = ST_RESP;
               err_nx   = 1'b1;
            end else if (op_q == OP_SET_SHIFT && shift_bad) begin
               state_nx = ST_RESP;
               err_nx   = 1'b1;
            end else begin
               case (op_q)
                  OP_WR_COEF:   state_nx = ST_WR_PULSE;
                  OP_RD_COEF:   state_nx = ST_RD_SET;
                  OP_SET_SHIFT: state_nx = ST_SH_PULSE;
                  default:      state_nx = ST_FLUSH;
               endcase
            end
         end
         ST_WR_PULSE: state_nx = ST_WR_WAIT;
         // A done arriving on the expiry cycle still counts as success.
         ST_WR_WAIT: begin
            if (f_coef_done) begin
               state_nx = ST_RESP;
            end else if (to_expired) begin
               state_nx = ST_RESP;
               err_nx   = 1'b1;
            end
         end
         ST_RD_SET:   state_nx = ST_RD_CAP;
         ST_RD_CAP:   state_nx = ST_RESP;
         ST_SH_PULSE: state_nx = ST_SH_WAIT;
         ST_SH_WAIT: begin
            if (f_shift_done) begin
               state_nx = ST_RESP;
            end else if (to_expired) begin
               state_nx = ST_RESP;
               err_nx   = 1'b1;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt == FW'(FLUSH_CYCLES - 1)) state_nx = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_q      <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         flush_cnt <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         f_addr    <= '0;
         f_coef    <= '0;
         f_shift_i <= '0;
      end else begin
         state     <= state_nx;
         flush_cnt <= (state == ST_FLUSH) ? flush_cnt + FW'(1) : '0;
         if (accept) begin
            op_q     <= cmd_op;
            addr_q   <= cmd_addr;
            data_q   <= cmd_data;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
         end
         if (state != ST_RESP && state_nx == ST_RESP) rsp_err <= err_nx;
         if (state == ST_CHECK && state_nx == ST_WR_PULSE) begin
            f_addr <= addr_q;
            f_coef <= data_q;
         end
         // Readout is registered in the filter, so the address leads the capture by a cycle.
         if (state == ST_CHECK && state_nx == ST_RD_SET) f_addr <= addr_q;
         if (state == ST_CHECK && state_nx == ST_SH_PULSE) f_shift_i <= data_q[SW-1:0];
         if (state == ST_RD_CAP) rsp_data <= f_coef_r;
      end
   end

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// tb/tb_fir_cfg_ctrl.sv - scoreboard bench for fir_cfg_ctrl with a behavioural filter and reference model
module tb_fir_cfg_ctrl;

   localparam int CW = 24;
   localparam int CC = 12;
   localparam int MS = 32;
   localparam int TO = 15;
   localparam int FC = 4;

   logic          clk;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [3:0]    cmd_addr;
   logic [CW-1:0] cmd_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [CW-1:0] rsp_data;
   logic          rsp_err;
   logic          busy;
   logic [3:0]    f_addr;
   logic [CW-1:0] f_coef;
   logic          f_coef_ready;
   logic          f_coef_done;
   logic [CW-1:0] f_coef_r;
   logic          f_shift_ready;
   logic [4:0]    f_shift_i;
   logic          f_shift_done;
   logic          f_flush;

   fir_cfg_ctrl #(
      .COEF_WIDTH   (CW),
      .COEF_COUNT   (CC),
      .MAX_SHIFT    (MS),
      .TIMEOUT      (TO),
      .FLUSH_CYCLES (FC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_addr      (cmd_addr),
      .cmd_data      (cmd_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .busy          (busy),
      .f_addr        (f_addr),
      .f_coef        (f_coef),
      .f_coef_ready  (f_coef_ready),
      .f_coef_done   (f_coef_done),
      .f_coef_r      (f_coef_r),
      .f_shift_ready (f_shift_ready),
      .f_shift_i     (f_shift_i),
      .f_shift_done  (f_shift_done),
      .f_flush       (f_flush)
   );

   typedef struct {
      int            acc;
      int            lat;
      logic          err;
      logic [CW-1:0] data;
      int            ncr;
      int            nsr;
      int            nfl;
      logic [3:0]    faddr;
      logic [CW-1:0] fcoef;
      logic [4:0]    shift;
      int            vcyc;
   } exp_t;

   exp_t          exp_q[$];
   logic [CW-1:0] ref_mem [16];
   logic [CW-1:0] fmem [16];
   int            n_pass = 0;
   int            n_total = 0;
   int            cyc = 0;
   int            fdelay = 0;
   int            hold_left = 0;
   bit            rand_mode = 0;
   int            viol_rdy = 0;
   int            viol_hold = 0;

   // Observed activity since the last response handshake.
   int            o_cr, o_sr, o_fl, o_nv, o_first;
   bit            o_seen;
   logic [3:0]    o_faddr;
   logic [CW-1:0] o_fcoef;
   logic [4:0]    o_shift;
   bit            hold_prev;
   logic [CW-1:0] prev_data;
   logic          prev_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural filter: registered readout, done pulse fdelay cycles after a strobe (0 = silent).
   initial begin
      int cd_c, cd_s;
      logic [3:0] prev_addr;
      cd_c = 0; cd_s = 0; prev_addr = '0;
      f_coef_done = 1'b0; f_shift_done = 1'b0; f_coef_r = '0;
      for (int i = 0; i < 16; i++) fmem[i] = '0;
      forever begin
         @(negedge clk);
         f_coef_done  = 1'b0;
         f_shift_done = 1'b0;
         if (rst) begin
            cd_c = 0; cd_s = 0;
         end else begin
            f_coef_r  = fmem[prev_addr];
            prev_addr = f_addr;
            if (cd_c > 0) begin cd_c--; if (cd_c == 0) f_coef_done = 1'b1; end
            if (cd_s > 0) begin cd_s--; if (cd_s == 0) f_shift_done = 1'b1; end
            if (f_coef_ready) begin fmem[f_addr] = f_coef; cd_c = fdelay; end
            if (f_shift_ready) cd_s = fdelay;
         end
      end
   end

   initial begin
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (rsp_valid && hold_left > 0) begin
            rsp_ready = 1'b0;
            hold_left--;
         end else begin
            rsp_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   end

   task automatic clear_obs();
      o_cr = 0; o_sr = 0; o_fl = 0; o_nv = 0; o_seen = 0; o_first = 0;
      o_faddr = '0; o_fcoef = '0; o_shift = '0;
   endtask

   initial begin
      clear_obs();
      hold_prev = 0; prev_data = '0; prev_err = 1'b0;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         clear_obs();
         hold_prev = 0;
      end else begin
         if (f_coef_ready) begin o_cr++; o_faddr = f_addr; o_fcoef = f_coef; end
         if (f_shift_ready) begin o_sr++; o_shift = f_shift_i; end
         if (f_flush) o_fl++;
         if (busy && cmd_ready) viol_rdy++;
         if (hold_prev && !(rsp_valid && rsp_data == prev_data && rsp_err == prev_err)) viol_hold++;
         hold_prev = rsp_valid && !rsp_ready;
         prev_data = rsp_data;
         prev_err  = rsp_err;
         if (rsp_valid) begin
            if (!o_seen) begin o_seen = 1; o_first = cyc; end
            o_nv++;
            if (rsp_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_rsp", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_err", 64'(rsp_err), 64'(e.err));
                  check("rsp_data", 64'(rsp_data), 64'(e.data));
                  check("latency", 64'(o_first - e.acc), 64'(e.lat));
                  check("coef_ready_pulses", 64'(o_cr), 64'(e.ncr));
                  check("shift_ready_pulses", 64'(o_sr), 64'(e.nsr));
                  check("flush_cycles", 64'(o_fl), 64'(e.nfl));
                  if (e.ncr == 1) begin
                     check("f_addr", 64'(o_faddr), 64'(e.faddr));
                     check("f_coef", 64'(o_fcoef), 64'(e.fcoef));
                  end
                  if (e.nsr == 1) check("f_shift_i", 64'(o_shift), 64'(e.shift));
                  if (e.vcyc >= 0) check("rsp_valid_cycles", 64'(o_nv), 64'(e.vcyc));
               end
               clear_obs();
            end
         end
      end
   end

   // Expected outcome comes from the command rules; the filter answer delay d decides timeouts.
   task automatic issue(input logic [1:0] op, input int addr, input logic [CW-1:0] data,
                        input int d, input int hold);
      exp_t e;
      int w;
      w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 300) begin @(negedge clk); w++; end
      if (!cmd_ready) begin
         check("cmd_ready_wait", 64'd0, 64'd1);
         return;
      end
      e.err = 1'b0; e.data = '0; e.ncr = 0; e.nsr = 0; e.nfl = 0; e.lat = 2;
      e.faddr = '0; e.fcoef = '0; e.shift = '0;
      e.vcyc = rand_mode ? -1 : hold + 1;
      case (op)
         2'd0: begin
            if (addr >= CC) e.err = 1'b1;
            else begin
               ref_mem[addr] = data;
               e.ncr = 1; e.faddr = 4'(addr); e.fcoef = data;
               if (d >= 1 && d <= TO) e.lat = 3 + d;
               else begin e.lat = 3 + TO; e.err = 1'b1; end
            end
         end
         2'd1: begin
            if (addr >= CC) e.err = 1'b1;
            else begin e.data = ref_mem[addr]; e.lat = 4; end
         end
         2'd2: begin
            if (data >= MS) e.err = 1'b1;
            else begin
               e.nsr = 1; e.shift = data[4:0];
               if (d >= 1 && d <= TO) e.lat = 3 + d;
               else begin e.lat = 3 + TO; e.err = 1'b1; end
            end
         end
         default: begin e.lat = 2 + FC; e.nfl = FC; end
      endcase
      fdelay    = d;
      hold_left = hold;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = 4'(addr);
      cmd_data  = data;
      e.acc     = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      logic [1:0] op;
      logic [CW-1:0] data;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_err, busy, f_addr, f_coef,
                              f_coef_ready, f_shift_ready, f_shift_i, f_flush}, 64'd0);
      #1 rst = 1'b0;

      issue(2'd0, 3, 24'h00ABCD, 1, 0);
      issue(2'd1, 3, 24'h0, 0, 0);
      issue(2'd0, 12, 24'h123456, 1, 0);
      issue(2'd1, 15, 24'h0, 0, 0);
      issue(2'd2, 0, 24'd40, 1, 0);
      issue(2'd2, 0, 24'd32, 1, 0);
      issue(2'd2, 0, 24'd31, 2, 0);
      issue(2'd0, 11, 24'hFEDCBA, 15, 0);
      issue(2'd2, 0, 24'd5, 0, 0);
      issue(2'd3, 0, 24'h0, 0, 10);
      issue(2'd0, 7, 24'h555AAA, 16, 0);
      issue(2'd1, 11, 24'h0, 0, 0);
      issue(2'd1, 7, 24'h0, 0, 0);

      // Reset in the middle of a write wait: strobes and response must vanish.
      issue(2'd0, 5, 24'h0C0FFE, 0, 0);
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      #1 check("reset_mid_cmd", {cmd_ready, rsp_valid, rsp_data, rsp_err, busy, f_addr, f_coef,
                                 f_coef_ready, f_shift_ready, f_shift_i, f_flush}, 64'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      issue(2'd1, 5, 24'h0, 0, 0);
      issue(2'd1, 3, 24'h0, 0, 0);

      rand_mode = 1;
      for (int n = 0; n < 60; n++) begin
         op = 2'($urandom_range(0, 3));
         data = (op == 2'd2) ? CW'($urandom_range(0, 40)) : CW'($urandom());
         issue(op, $urandom_range(0, 15), data, $urandom_range(0, 17), 0);
      end

      for (int i = 0; i < 600 && exp_q.size() > 0; i++) @(negedge clk);
      check("responses_outstanding", 64'(exp_q.size()), 64'd0);
      check("cmd_ready_while_busy", 64'(viol_rdy), 64'd0);
      check("rsp_hold_stable", 64'(viol_hold), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
